board_memory_rw: RTL and testbench

Registered, parametrised game-board store for the Gomoku datapath. It holds every board cell in flops and accepts one write per cycle. It serves a random-access read port with one-cycle latency, and a line-scan engine that streams `SCAN_LEN` consecutive cells along a chosen direction for the win checker. A flattened copy of the whole board is exported for the VGA/draw logic and for legacy combinational readers.

---
 rtl/board_memory_rw.sv | 188 ++++++++++++++++++
 tb/tb_board_memory_rw.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_memory_rw.sv
// Gomoku board store: flop-based N x N cell array with one write port, a
// one-cycle random read port, a line-scan engine and a flattened board view.
module board_memory_rw #(
  parameter int COORD_BITS = 4,
  parameter int CELL_BITS  = 2,
  parameter int SCAN_LEN   = 5
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic                                                   wr_en,
  input  logic [2*COORD_BITS-1:0]                                wr_xy,
  input  logic [CELL_BITS-1:0]                                   wr_data,
  input  logic                                                   rd_req,
  input  logic [2*COORD_BITS-1:0]                                rd_xy,
  output logic                                                   rd_valid,
  output logic [CELL_BITS-1:0]                                   rd_data,
  input  logic                                                   scan_start,
  input  logic [2*COORD_BITS-1:0]                                scan_xy,
  input  logic [1:0]                                             scan_dir,
  output logic                                                   scan_busy,
  output logic                                                   scan_valid,
  output logic [CELL_BITS-1:0]                                   scan_data,
  output logic                                                   scan_oob,
  output logic                                                   scan_last,
  output logic [(2**COORD_BITS)*(2**COORD_BITS)*CELL_BITS-1:0]   board_out
);

  localparam int N       = 2 ** COORD_BITS;
  localparam int BOARD_W = N * N * CELL_BITS;
  localparam logic [COORD_BITS-1:0] K_LAST = COORD_BITS'(SCAN_LEN - 1);

  typedef enum logic [0:0] {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  // Cell index is y*N + x, i.e. {y, x} concatenated.
  function automatic logic [CELL_BITS-1:0] cell_at(
    input logic [BOARD_W-1:0]      board,
    input logic [2*COORD_BITS-1:0] idx
  );
    return board[idx*CELL_BITS +: CELL_BITS];
  endfunction

  function automatic logic [2*COORD_BITS-1:0] xy_to_idx(input logic [2*COORD_BITS-1:0] xy);
    return {xy[COORD_BITS-1:0], xy[2*COORD_BITS-1:COORD_BITS]};
  endfunction

  logic [BOARD_W-1:0]      board_r;
  logic                    rd_valid_r;
  logic [CELL_BITS-1:0]    rd_data_r;
  scan_state_t             state_r;
  scan_state_t             state_next_s;
  logic [COORD_BITS-1:0]   k_r;
  logic [COORD_BITS-1:0]   org_x_r;
  logic [COORD_BITS-1:0]   org_y_r;
  logic [1:0]              dir_r;
  logic                    scan_busy_r;
  logic                    scan_valid_r;
  logic [CELL_BITS-1:0]    scan_data_r;
  logic                    scan_oob_r;
  logic                    scan_last_r;
  logic [COORD_BITS:0]     k_ext_s;
  logic [COORD_BITS:0]     scan_x_s;
  logic [COORD_BITS:0]     scan_y_s;
  logic                    scan_oob_s;
  logic [CELL_BITS-1:0]    scan_cell_s;

  // Cell storage: one write per edge, whole board cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      board_r <= '0;
    end else if (wr_en) begin
      board_r[xy_to_idx(wr_xy)*CELL_BITS +: CELL_BITS] <= wr_data;
    end
  end

  // Random read port: samples storage before any same-edge write lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_req;
      if (rd_req) begin
        rd_data_r <= cell_at(board_r, xy_to_idx(rd_xy));
      end
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= SCAN_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scan FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SCAN_IDLE: begin
        if (scan_start) state_next_s = SCAN_RUN;
        else            state_next_s = SCAN_IDLE;
      end
      SCAN_RUN: begin
        if (k_r == K_LAST) state_next_s = SCAN_IDLE;
        else               state_next_s = SCAN_RUN;
      end
      default: state_next_s = SCAN_IDLE;
    endcase
  end

  // Beat coordinate, one bit wider than a coordinate so off-board steps show
  // up in the top bit: positive overflow (>= N) and negative values both set it.
  always_comb begin
    k_ext_s  = {1'b0, k_r};
    scan_x_s = {1'b0, org_x_r};
    scan_y_s = {1'b0, org_y_r};
    case (dir_r)
      2'd0: scan_x_s = {1'b0, org_x_r} + k_ext_s;
      2'd1: scan_y_s = {1'b0, org_y_r} + k_ext_s;
      2'd2: begin
        scan_x_s = {1'b0, org_x_r} + k_ext_s;
        scan_y_s = {1'b0, org_y_r} + k_ext_s;
      end
      2'd3: begin
        scan_x_s = {1'b0, org_x_r} + k_ext_s;
        scan_y_s = {1'b0, org_y_r} - k_ext_s;
      end
      default: begin
        scan_x_s = {1'b0, org_x_r};
        scan_y_s = {1'b0, org_y_r};
      end
    endcase
    scan_oob_s  = scan_x_s[COORD_BITS] | scan_y_s[COORD_BITS];
    scan_cell_s = cell_at(board_r, {scan_y_s[COORD_BITS-1:0], scan_x_s[COORD_BITS-1:0]});
  end

  // Scan origin/direction latch, step counter and registered beat outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      org_x_r      <= '0;
      org_y_r      <= '0;
      dir_r        <= 2'd0;
      k_r          <= '0;
      scan_busy_r  <= 1'b0;
      scan_valid_r <= 1'b0;
      scan_data_r  <= '0;
      scan_oob_r   <= 1'b0;
      scan_last_r  <= 1'b0;
    end else begin
      if (state_r == SCAN_IDLE && scan_start) begin
        org_x_r <= scan_xy[2*COORD_BITS-1:COORD_BITS];
        org_y_r <= scan_xy[COORD_BITS-1:0];
        dir_r   <= scan_dir;
        k_r     <= '0;
      end else if (state_r == SCAN_RUN) begin
        k_r <= k_r + COORD_BITS'(1);
      end
      if (state_r == SCAN_RUN) begin
        scan_busy_r  <= 1'b1;
        scan_valid_r <= 1'b1;
        scan_oob_r   <= scan_oob_s;
        scan_data_r  <= scan_oob_s ? '0 : scan_cell_s;
        scan_last_r  <= (k_r == K_LAST);
      end else begin
        scan_busy_r  <= 1'b0;
        scan_valid_r <= 1'b0;
        scan_oob_r   <= 1'b0;
        scan_data_r  <= '0;
        scan_last_r  <= 1'b0;
      end
    end
  end

  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;
  assign scan_busy  = scan_busy_r;
  assign scan_valid = scan_valid_r;
  assign scan_data  = scan_data_r;
  assign scan_oob   = scan_oob_r;
  assign scan_last  = scan_last_r;
  assign board_out  = board_r;

endmodule

// File: tb/tb_board_memory_rw.sv
// Directed plus randomized bench for board_memory_rw against a cell-array
// model holding the board as plain integers indexed by (x, y).
module tb_board_memory_rw;

  localparam int CB = 4;
  localparam int CW = 2;
  localparam int SL = 5;
  localparam int N  = 16;
  localparam int BW = N * N * CW;

  logic            clock = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [2*CB-1:0] wr_xy;
  logic [CW-1:0]   wr_data;
  logic            rd_req;
  logic [2*CB-1:0] rd_xy;
  logic            rd_valid;
  logic [CW-1:0]   rd_data;
  logic            scan_start;
  logic [2*CB-1:0] scan_xy;
  logic [1:0]      scan_dir;
  logic            scan_busy;
  logic            scan_valid;
  logic [CW-1:0]   scan_data;
  logic            scan_oob;
  logic            scan_last;
  logic [BW-1:0]   board_out;

  int checks = 0;
  int errors = 0;
  int model [N*N];

  board_memory_rw #(.COORD_BITS(CB), .CELL_BITS(CW), .SCAN_LEN(SL)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_xy(wr_xy), .wr_data(wr_data),
    .rd_req(rd_req), .rd_xy(rd_xy), .rd_valid(rd_valid), .rd_data(rd_data),
    .scan_start(scan_start), .scan_xy(scan_xy), .scan_dir(scan_dir),
    .scan_busy(scan_busy), .scan_valid(scan_valid), .scan_data(scan_data),
    .scan_oob(scan_oob), .scan_last(scan_last), .board_out(board_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*CB-1:0] pack(input int x, input int y);
    return {x[CB-1:0], y[CB-1:0]};
  endfunction

  function automatic logic [BW-1:0] model_board();
    logic [BW-1:0] v;
    int c;
    v = '0;
    for (int i = 0; i < N*N; i++) begin
      c = model[i];
      v[i*CW +: CW] = c[CW-1:0];
    end
    return v;
  endfunction

  // Expected beat k of a scan: walk k steps from the origin on the plain grid.
  task automatic beat_exp(input int ox, input int oy, input int dir, input int k,
                          output int data, output int oob);
    int dx, dy, x, y;
    dx = (dir == 1) ? 0 : 1;
    dy = (dir == 0) ? 0 : ((dir == 3) ? -1 : 1);
    x = ox + dx * k;
    y = oy + dy * k;
    oob  = (x < 0 || x >= N || y < 0 || y >= N) ? 1 : 0;
    data = (oob != 0) ? 0 : model[y*N + x];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_cell(input int x, input int y, input int v);
    wr_en = 1'b1; wr_xy = pack(x, y); wr_data = v[CW-1:0];
    tick();
    wr_en = 1'b0;
    model[y*N + x] = v;
  endtask

  task automatic read_check(input int x, input int y, input string tag);
    rd_req = 1'b1; rd_xy = pack(x, y);
    tick();
    rd_req = 1'b0;
    chk({tag, "_valid"}, BW'(rd_valid), BW'(1));
    chk({tag, "_data"}, BW'(rd_data), BW'(model[y*N + x]));
  endtask

  // Runs a full scan; optionally pulses scan_start after beat pulse_beat and
  // writes (wx,wy)=wv during the cycle that presents beat wbeat.
  task automatic run_scan(input int ox, input int oy, input int dir, input int pulse_beat,
                          input int wbeat, input int wx, input int wy, input int wv,
                          input string tag);
    int ed, eo, pend;
    pend = 0;
    scan_start = 1'b1; scan_xy = pack(ox, oy); scan_dir = dir[1:0];
    tick();
    scan_start = 1'b0; scan_xy = pack(ox ^ 5, oy ^ 3); scan_dir = ~dir[1:0];
    chk({tag, "_pre_busy"}, BW'(scan_busy), BW'(0));
    for (int k = 0; k < SL; k++) begin
      tick();
      beat_exp(ox, oy, dir, k, ed, eo);
      chk($sformatf("%s_b%0d_valid", tag, k), BW'(scan_valid), BW'(1));
      chk($sformatf("%s_b%0d_busy", tag, k), BW'(scan_busy), BW'(1));
      chk($sformatf("%s_b%0d_data", tag, k), BW'(scan_data), BW'(ed));
      chk($sformatf("%s_b%0d_oob", tag, k), BW'(scan_oob), BW'(eo));
      chk($sformatf("%s_b%0d_last", tag, k), BW'(scan_last), BW'(k == SL - 1));
      if (pend != 0) begin
        model[wy*N + wx] = wv;
        pend = 0;
      end
      scan_start = (k == pulse_beat) ? 1'b1 : 1'b0;
      scan_xy    = pack(0, 0);
      if (k == wbeat) begin
        wr_en = 1'b1; wr_xy = pack(wx, wy); wr_data = wv[CW-1:0];
        pend = 1;
      end else begin
        wr_en = 1'b0;
      end
    end
    scan_start = 1'b0; wr_en = 1'b0;
    tick();
    chk({tag, "_end_busy"}, BW'(scan_busy), BW'(0));
    chk({tag, "_end_valid"}, BW'(scan_valid), BW'(0));
  endtask

  initial begin
    int held, old, rx, ry, wx, wy, wv, do_wr, do_rd;
    for (int i = 0; i < N*N; i++) model[i] = 0;
    reset = 1'b0; wr_en = 1'b0; wr_xy = '0; wr_data = '0; rd_req = 1'b0; rd_xy = '0;
    scan_start = 1'b0; scan_xy = '0; scan_dir = 2'd0;
    tick(); tick();
    chk("rst_rd_valid", BW'(rd_valid), BW'(0));
    chk("rst_rd_data", BW'(rd_data), BW'(0));
    chk("rst_scan_busy", BW'(scan_busy), BW'(0));
    chk("rst_scan_valid", BW'(scan_valid), BW'(0));
    chk("rst_scan_misc", BW'({scan_data, scan_oob, scan_last}), BW'(0));
    chk("rst_board", board_out, '0);
    reset = 1'b1;
    tick();

    // Basic write then read, plus board_out placement.
    write_cell(3, 4, 1);
    read_check(3, 4, "rd34");
    chk("board34", BW'(board_out[(4*16+3)*2 +: 2]), BW'(1));
    tick();
    chk("rd_idle_valid", BW'(rd_valid), BW'(0));
    chk("rd_hold_data", BW'(rd_data), BW'(1));

    // Same-edge read and write return the old value; next read sees new.
    wr_en = 1'b1; wr_xy = pack(7, 7); wr_data = 2'd2;
    rd_req = 1'b1; rd_xy = pack(7, 7);
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    chk("rw_same_old", BW'(rd_data), BW'(0));
    model[7*N + 7] = 2;
    read_check(7, 7, "rw_next_new");

    // Horizontal run of player B, scanned along +x.
    for (int x = 2; x <= 6; x++) write_cell(x, 5, 2);
    run_scan(2, 5, 0, -1, -1, 0, 0, 0, "scan_row");

    // Diagonal that walks off the top-right corner.
    write_cell(14, 1, 1);
    write_cell(15, 0, 3);
    run_scan(14, 1, 3, -1, -1, 0, 0, 0, "scan_oob");

    // Start pulse mid-scan ignored; write at beat 1 seen by beat 3.
    write_cell(4, 8, 1);
    run_scan(1, 5, 2, 2, 1, 4, 8, 2, "scan_mid");

    // Randomized writes and reads, including same-cell collisions.
    held = rd_data;
    for (int i = 0; i < 60; i++) begin
      wx = $urandom_range(N-1); wy = $urandom_range(N-1); wv = $urandom_range(3);
      rx = $urandom_range(N-1); ry = $urandom_range(N-1);
      if ($urandom_range(3) == 0) begin rx = wx; ry = wy; end
      do_wr = $urandom_range(1); do_rd = $urandom_range(1);
      wr_en = do_wr[0]; wr_xy = pack(wx, wy); wr_data = wv[CW-1:0];
      rd_req = do_rd[0]; rd_xy = pack(rx, ry);
      old = model[ry*N + rx];
      tick();
      if (do_rd != 0) held = old;
      chk($sformatf("rnd%0d_valid", i), BW'(rd_valid), BW'(do_rd));
      chk($sformatf("rnd%0d_data", i), BW'(rd_data), BW'(held));
      if (do_wr != 0) model[wy*N + wx] = wv;
    end
    wr_en = 1'b0; rd_req = 1'b0;
    chk("rnd_board", board_out, model_board());

    for (int i = 0; i < 6; i++) begin
      run_scan($urandom_range(N-1), $urandom_range(N-1), $urandom_range(3),
               -1, -1, 0, 0, 0, $sformatf("rscan%0d", i));
    end

    // Reset pulled low during beat 1 of a scan.
    scan_start = 1'b1; scan_xy = pack(2, 5); scan_dir = 2'd0;
    tick();
    scan_start = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", BW'(scan_valid), BW'(1));
    #2 reset = 1'b0;
    #1;
    chk("async_busy", BW'(scan_busy), BW'(0));
    chk("async_valid", BW'(scan_valid), BW'(0));
    chk("async_board", board_out, '0);
    for (int i = 0; i < N*N; i++) model[i] = 0;
    #3 reset = 1'b1;
    tick();
    chk("no_resume_busy", BW'(scan_busy), BW'(0));
    tick();
    chk("no_resume_valid", BW'(scan_valid), BW'(0));
    read_check(3, 5, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
